ag32gbd_cam_cart: RTL and testbench

- Game Boy Camera (MAC-GBD style) cartridge mapper and camera controller for the AG32 FPGA fabric.
- Decodes the Game Boy cartridge bus and tracks ROM and RAM bank registers.
- Drives external ROM/SRAM address and chip-select lines, serves test-pattern read data on cart_d, and sequences an M64282FP-style image sensor.
- All cartridge inputs are asynchronous and are synchronised into sys_clock.

---
 rtl/ag32gbd_cam_cart.sv | 223 ++++++++++++++++++++++
 tb/tb_ag32gbd_cam_cart.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ag32gbd_cam_cart.sv
// Game Boy Camera cartridge mapper: bus decode, ROM/RAM banking, test-pattern reads
// and an M64282FP-style sensor capture sequencer, all in the sys_clock domain.
module ag32gbd_cam_cart #(
    parameter int unsigned XCK_DIV     = 100,
    parameter int unsigned CAPTURE_XCK = 200
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        cart_CLK,
    input  logic [15:0] cart_a,
    inout  wire  [7:0]  cart_d,
    input  logic        cart_nCS,
    input  logic        cart_nRD,
    input  logic        cart_nWR,
    output logic        cart_nRST,
    output logic [8:0]  rom_a,
    output logic        rom_nCS,
    output logic [3:0]  ram_a,
    output logic        ram_nCS,
    output logic        ram_ce2,
    output logic        ram_nWE,
    output logic        sens_xck,
    output logic        sens_reset,
    output logic        sens_load,
    output logic        sens_sin,
    output logic        sens_start,
    output logic        sens_read,
    output logic        dbgout6,
    output logic        dbgout8,
    output logic [7:0]  debug_ROM_BANK,
    output logic [7:0]  debug_RAM_BANK,
    output logic [7:0]  debug_bram_output
);
    localparam int unsigned DW = (XCK_DIV > 1) ? $clog2(XCK_DIV) : 1;
    localparam int unsigned TW = $clog2(CAPTURE_XCK + 1);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_LOAD, S_START, S_EXPOSE, S_DONE} state_t;

    logic [15:0]   a_m_q, a_s_q, wa_q;
    logic [7:0]    d_m_q, d_s_q, wd_q;
    logic [2:0]    ctl_m_q, ctl_s_q;   // {nCS, nRD, nWR}
    logic          clk_m_q, cart_clk_unused_q;
    logic          nwr_prev_q, wcs_q;
    logic [5:0]    rom_bank_q;
    logic [4:0]    ram_bank_q;
    logic [7:0]    cam_q [8];
    logic [DW-1:0] div_q;
    logic          xck_q;
    state_t        state_q, state_d;
    logic [TW-1:0] total_q, total_d;
    logic [2:0]    reg_idx_q, reg_idx_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic          sres_q, sres_d;
    logic [7:0]    bram_q;
    logic          ncs_s, nrd_s, nwr_s, commit, cam_wr, busy, done_clr, xck_tick, xck_rise;
    logic          rom_win, ram_win, drv;
    logic [7:0]    dout;
    logic [10:0]   word;

    assign ncs_s    = ctl_s_q[2];
    assign nrd_s    = ctl_s_q[1];
    assign nwr_s    = ctl_s_q[0];
    assign commit   = nwr_s && !nwr_prev_q;
    assign busy     = cam_q[0][0];
    assign cam_wr   = commit && !wcs_q && (wa_q[15:13] == 3'b101) && (wa_q[12:3] == '0) && ram_bank_q[4];
    assign xck_tick = (div_q == DW'(XCK_DIV - 1));
    assign xck_rise = xck_tick && !xck_q;

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            a_m_q <= '0;  a_s_q <= '0;
            d_m_q <= '0;  d_s_q <= '0;
            ctl_m_q <= '1; ctl_s_q <= '1;
            clk_m_q <= 1'b0; cart_clk_unused_q <= 1'b0;
            nwr_prev_q <= 1'b1;
            wa_q <= '0; wd_q <= '0; wcs_q <= 1'b1;
        end else begin
            a_m_q <= cart_a;   a_s_q <= a_m_q;
            d_m_q <= cart_d;   d_s_q <= d_m_q;
            ctl_m_q <= {cart_nCS, cart_nRD, cart_nWR};
            ctl_s_q <= ctl_m_q;
            clk_m_q <= cart_CLK; cart_clk_unused_q <= clk_m_q;
            nwr_prev_q <= nwr_s;
            // Hold the last address/data seen while nWR was low; the commit uses these.
            if (!nwr_s) begin
                wa_q <= a_s_q; wd_q <= d_s_q; wcs_q <= ncs_s;
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            rom_bank_q <= '0;
            ram_bank_q <= '0;
            for (int unsigned i = 0; i < 8; i++) cam_q[i] <= '0;
        end else begin
            if (commit && !wa_q[15]) begin
                if (wa_q[14:13] == 2'b01)      rom_bank_q <= wd_q[5:0];
                else if (wa_q[14:13] == 2'b10) ram_bank_q <= wd_q[4:0];
            end
            if (cam_wr) begin
                if (wa_q[2:0] != 3'd0)  cam_q[wa_q[2:0]]  <= wd_q;
                else if (busy)          cam_q[0][2:1]     <= wd_q[2:1];
                else                    cam_q[0]          <= wd_q;
            end
            if (done_clr) cam_q[0][0] <= 1'b0;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            div_q <= '0;
            xck_q <= 1'b0;
        end else if (xck_tick) begin
            div_q <= '0;
            xck_q <= ~xck_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            total_q   <= '0;
            reg_idx_q <= '0;
            bit_idx_q <= '0;
            sres_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            reg_idx_q <= reg_idx_d;
            bit_idx_q <= bit_idx_d;
            sres_q    <= sres_d;
        end
    end

    // total_q counts xck periods since capture start; RST is period 1, DONE is the last.
    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        reg_idx_d = reg_idx_q;
        bit_idx_d = bit_idx_q;
        sres_d    = sres_q;
        done_clr  = 1'b0;
        if (xck_rise) begin
            if (state_q != S_IDLE && state_q != S_DONE) total_d = total_q + 1'b1;
            case (state_q)
                S_IDLE: if (busy) begin
                    state_d = S_RST;
                    total_d = TW'(1);
                    sres_d  = 1'b0;
                end
                S_RST: begin
                    state_d   = S_LOAD;
                    sres_d    = 1'b1;
                    reg_idx_d = 3'd1;
                    bit_idx_d = 4'd10;
                end
                S_LOAD: begin
                    if (bit_idx_q == 4'd0) begin
                        if (reg_idx_q == 3'd7) state_d = S_START;
                        else begin
                            reg_idx_d = reg_idx_q + 3'd1;
                            bit_idx_d = 4'd10;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q - 4'd1;
                    end
                end
                S_START:  state_d = S_EXPOSE;
                S_EXPOSE: if (total_q >= TW'(CAPTURE_XCK - 1)) state_d = S_DONE;
                S_DONE: begin
                    state_d  = S_IDLE;
                    done_clr = 1'b1;
                end
                default:  state_d = S_IDLE;
            endcase
        end
    end

    assign word       = {reg_idx_q, cam_q[reg_idx_q]};
    assign sens_xck   = xck_q;
    assign sens_reset = sres_q;
    assign sens_sin   = (state_q == S_LOAD) && word[bit_idx_q];
    assign sens_load  = (state_q == S_LOAD) && (bit_idx_q == 4'd0);
    assign sens_start = (state_q == S_START);
    assign sens_read  = (state_q == S_EXPOSE);

    assign rom_win = !a_s_q[15];
    assign ram_win = !ncs_s && (a_s_q[15:13] == 3'b101);
    assign drv     = !reset && !nrd_s && nwr_s && (rom_win || ram_win);

    always_comb begin
        dout = 8'h00;
        if (rom_win) begin
            if (a_s_q[14]) dout = {2'b00, rom_bank_q};
        end else if (ram_bank_q[4]) begin
            if (a_s_q[12:0] == '0) dout = {7'b1110000, busy};
        end else begin
            dout = {4'hF, ram_bank_q[3:0]};
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset)    bram_q <= '0;
        else if (drv) bram_q <= dout;
    end

    assign cart_d            = drv ? dout : 8'bzzzz_zzzz;
    assign cart_nRST         = ~reset;
    assign ram_ce2           = ~reset;
    assign rom_nCS           = ~(rom_win && !nrd_s);
    assign rom_a             = (rom_win && a_s_q[14]) ? {3'b000, rom_bank_q} : '0;
    assign ram_nCS           = ~(ram_win && !ram_bank_q[4]);
    assign ram_a             = ram_bank_q[3:0];
    assign ram_nWE           = ram_nCS ? 1'b1 : nwr_s;
    assign dbgout6           = xck_q;
    assign dbgout8           = nwr_s;
    assign debug_ROM_BANK    = {2'b00, rom_bank_q};
    assign debug_RAM_BANK    = {3'b000, ram_bank_q};
    assign debug_bram_output = bram_q;
endmodule

// File: tb/tb_ag32gbd_cam_cart.sv
// Bench for ag32gbd_cam_cart: table of bus transactions checked through a scoreboard,
// plus hand sequences for capture timing, sensor serial stream and reset abort.
module tb_ag32gbd_cam_cart;
    logic        sys_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        cart_CLK  = 1'b0;
    logic [15:0] cart_a    = '0;
    logic        cart_nCS  = 1'b1;
    logic        cart_nRD  = 1'b1;
    logic        cart_nWR  = 1'b1;
    logic        tb_den    = 1'b0;
    logic [7:0]  tb_d      = '0;
    wire  [7:0]  cart_d;
    logic        cart_nRST, rom_nCS, ram_nCS, ram_ce2, ram_nWE;
    logic [8:0]  rom_a;
    logic [3:0]  ram_a;
    logic        sens_xck, sens_reset, sens_load, sens_sin, sens_start, sens_read;
    logic        dbgout6, dbgout8;
    logic [7:0]  debug_ROM_BANK, debug_RAM_BANK, debug_bram_output;

    assign cart_d = tb_den ? tb_d : 8'bzzzz_zzzz;

    ag32gbd_cam_cart #(.XCK_DIV(100), .CAPTURE_XCK(200)) dut (
        .sys_clock(sys_clock), .reset(reset), .cart_CLK(cart_CLK), .cart_a(cart_a),
        .cart_d(cart_d), .cart_nCS(cart_nCS), .cart_nRD(cart_nRD), .cart_nWR(cart_nWR),
        .cart_nRST(cart_nRST), .rom_a(rom_a), .rom_nCS(rom_nCS), .ram_a(ram_a),
        .ram_nCS(ram_nCS), .ram_ce2(ram_ce2), .ram_nWE(ram_nWE), .sens_xck(sens_xck),
        .sens_reset(sens_reset), .sens_load(sens_load), .sens_sin(sens_sin),
        .sens_start(sens_start), .sens_read(sens_read), .dbgout6(dbgout6), .dbgout8(dbgout8),
        .debug_ROM_BANK(debug_ROM_BANK), .debug_RAM_BANK(debug_RAM_BANK),
        .debug_bram_output(debug_bram_output)
    );

    always #5  sys_clock = ~sys_clock;
    always #37 cart_CLK  = ~cart_CLK;

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  ed;
        logic [8:0]  erom_a;
        logic        erom_ncs;
        logic [3:0]  eram_a;
        logic        eram_ncs;
        logic [7:0]  erb;
        logic [7:0]  emb;
    } vec_t;

    vec_t        vt[$];
    vec_t        sb[$];
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];
    logic [10:0] sh_q = '0;
    int          start_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(negedge sens_xck) begin
        logic [10:0] nxt;
        nxt = {sh_q[9:0], sens_sin};
        sh_q <= nxt;
        if (sens_load) got_q.push_back(nxt);
    end

    always @(posedge sens_start) start_cnt <= start_cnt + 1;

    initial begin
        repeat (95000) @(posedge sys_clock);
        $display("FAIL watchdog: run got %0d vectors deep, required completion", n_vec);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic vec_t W(input logic [15:0] a, input logic [7:0] d);
        vec_t v;
        v = '{wr: 1'b1, a: a, d: d, ed: '0, erom_a: '0, erom_ncs: 1'b1, eram_a: '0,
              eram_ncs: 1'b1, erb: '0, emb: '0};
        return v;
    endfunction

    function automatic vec_t R(input logic [15:0] a, input logic [7:0] ed, input logic [8:0] ra,
                               input logic rn, input logic [3:0] ma, input logic mn,
                               input logic [7:0] rb, input logic [7:0] mb);
        vec_t v;
        v = '{wr: 1'b0, a: a, d: '0, ed: ed, erom_a: ra, erom_ncs: rn, eram_a: ma,
              eram_ncs: mn, erb: rb, emb: mb};
        return v;
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge sys_clock);
        cart_a = a; cart_nCS = !(a[15:13] == 3'b101); tb_d = d; tb_den = 1'b1;
        repeat (3) @(negedge sys_clock);
        cart_nWR = 1'b0;
        repeat (6) @(negedge sys_clock);
        cart_nWR = 1'b1;
        repeat (6) @(negedge sys_clock);
        cart_nCS = 1'b1; tb_den = 1'b0;
        repeat (2) @(negedge sys_clock);
    endtask

    task automatic read_begin(input logic [15:0] a);
        @(negedge sys_clock);
        cart_a = a; cart_nCS = !(a[15:13] == 3'b101); cart_nRD = 1'b0;
        repeat (6) @(negedge sys_clock);
    endtask

    task automatic read_end();
        cart_nRD = 1'b1; cart_nCS = 1'b1;
        repeat (4) @(negedge sys_clock);
    endtask

    task automatic read_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        read_begin(a);
        chk(name, 16'(cart_d), 16'(exp));
        read_end();
    endtask

    initial begin
        vec_t e;
        // ROM window, bank register, ignored writes, bank 0 not remapped
        vt.push_back(R(16'h2000, 8'h00, 9'h000, 1'b0, 4'h0, 1'b1, 8'h00, 8'h00));
        vt.push_back(R(16'h6000, 8'h00, 9'h000, 1'b0, 4'h0, 1'b1, 8'h00, 8'h00));
        vt.push_back(W(16'h2000, 8'h05));
        vt.push_back(R(16'h6000, 8'h05, 9'h005, 1'b0, 4'h0, 1'b1, 8'h05, 8'h00));
        vt.push_back(R(16'h2000, 8'h00, 9'h000, 1'b0, 4'h0, 1'b1, 8'h05, 8'h00));
        vt.push_back(W(16'h0000, 8'h1F));
        vt.push_back(W(16'h7000, 8'h3F));
        vt.push_back(R(16'h6000, 8'h05, 9'h005, 1'b0, 4'h0, 1'b1, 8'h05, 8'h00));
        // RAM window in SRAM mode
        vt.push_back(R(16'hA010, 8'hF0, 9'h000, 1'b1, 4'h0, 1'b0, 8'h05, 8'h00));
        vt.push_back(W(16'h4000, 8'h01));
        vt.push_back(R(16'hA010, 8'hF1, 9'h000, 1'b1, 4'h1, 1'b0, 8'h05, 8'h01));
        vt.push_back(W(16'h2000, 8'h3F));
        vt.push_back(R(16'h4000, 8'h3F, 9'h03F, 1'b0, 4'h1, 1'b1, 8'h3F, 8'h01));
        vt.push_back(W(16'h2000, 8'h00));
        vt.push_back(R(16'h7FFF, 8'h00, 9'h000, 1'b0, 4'h1, 1'b1, 8'h00, 8'h01));
        // camera-register mode
        vt.push_back(W(16'h4000, 8'h10));
        vt.push_back(R(16'hA010, 8'h00, 9'h000, 1'b1, 4'h0, 1'b1, 8'h00, 8'h10));
        vt.push_back(R(16'hA000, 8'hE0, 9'h000, 1'b1, 4'h0, 1'b1, 8'h00, 8'h10));
        for (int n = 1; n < 8; n++) vt.push_back(W(16'hA000 + 16'(n), 8'hA0 + 8'(n)));
        vt.push_back(W(16'hA008, 8'hFF));
        vt.push_back(R(16'hA000, 8'hE0, 9'h000, 1'b1, 4'h0, 1'b1, 8'h00, 8'h10));
        vt.push_back(R(16'hA003, 8'h00, 9'h000, 1'b1, 4'h0, 1'b1, 8'h00, 8'h10));

        // reset state
        repeat (4) @(negedge sys_clock);
        chk("rst sens", 16'({sens_xck, sens_reset, sens_load, sens_sin, sens_start, sens_read}), 16'h0);
        chk("rst nRST/ce2", 16'({cart_nRST, ram_ce2}), 16'h0);
        chk("rst nCS/nWE", 16'({rom_nCS, ram_nCS, ram_nWE}), 16'h7);
        chk("rst debug", {debug_ROM_BANK, debug_RAM_BANK}, 16'h0);
        chk("rst bram", 16'(debug_bram_output), 16'h0);
        reset = 1'b0;
        repeat (4) @(negedge sys_clock);
        chk("run nRST/ce2", 16'({cart_nRST, ram_ce2}), 16'h3);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].wr) begin
                bus_write(vt[i].a, vt[i].d);
            end else begin
                sb.push_back(vt[i]);
                read_begin(vt[i].a);
                e = sb.pop_front();
                chk($sformatf("v%0d cart_d", i), 16'(cart_d), 16'(e.ed));
                chk($sformatf("v%0d bram", i), 16'(debug_bram_output), 16'(e.ed));
                chk($sformatf("v%0d rom_nCS", i), 16'(rom_nCS), 16'(e.erom_ncs));
                chk($sformatf("v%0d ram_nCS", i), 16'(ram_nCS), 16'(e.eram_ncs));
                if (!e.erom_ncs) chk($sformatf("v%0d rom_a", i), 16'(rom_a), 16'(e.erom_a));
                if (!e.eram_ncs) chk($sformatf("v%0d ram_a", i), 16'(ram_a), 16'(e.eram_a));
                chk($sformatf("v%0d banks", i), {debug_ROM_BANK, debug_RAM_BANK}, {e.erb, e.emb});
                read_end();
            end
        end

        // SRAM write strobe passes through in SRAM mode, stays off in camera mode
        bus_write(16'h4000, 8'h02);
        for (int m = 0; m < 2; m++) begin
            @(negedge sys_clock);
            cart_a = (m == 0) ? 16'hA010 : 16'hA005; cart_nCS = 1'b0; tb_d = 8'hA5; tb_den = 1'b1;
            repeat (2) @(negedge sys_clock);
            cart_nWR = 1'b0;
            repeat (5) @(negedge sys_clock);
            chk($sformatf("wr%0d ram_nWE", m), 16'(ram_nWE), (m == 0) ? 16'h0 : 16'h1);
            chk($sformatf("wr%0d ram_nCS", m), 16'(ram_nCS), (m == 0) ? 16'h0 : 16'h1);
            if (m == 0) chk("wr0 ram_a", 16'(ram_a), 16'h2);
            cart_nWR = 1'b1;
            repeat (5) @(negedge sys_clock);
            cart_nCS = 1'b1; tb_den = 1'b0;
            if (m == 0) bus_write(16'h4000, 8'h10);
        end

        // capture: busy bit, write during capture, sensor stream
        for (int n = 1; n < 8; n++) exp_q.push_back({3'(n), 8'hA0 + 8'(n)});
        bus_write(16'hA000, 8'h03);
        repeat (1000) @(negedge sys_clock);
        read_chk("busy@10us", 16'hA000, 8'hE1);
        bus_write(16'hA000, 8'h06);
        read_chk("busy after bit-clear write", 16'hA000, 8'hE1);
        repeat (60000) @(negedge sys_clock);
        read_chk("busy@600us", 16'hA000, 8'hE0);
        chk("start pulses", 16'(start_cnt), 16'd1);
        chk("sens_reset held", 16'(sens_reset), 16'h1);
        chk("loaded regs", 16'(got_q.size()), 16'd7);
        while (exp_q.size() > 0) begin
            logic [10:0] x;
            x = exp_q.pop_front();
            if (got_q.size() == 0) chk("sin word missing", 16'hFFFF, 16'(x));
            else                   chk($sformatf("sin word %0d", x[10:8]), 16'(got_q.pop_front()), 16'(x));
        end

        // reset mid-capture, with a read of A000 in flight and the bench also driving the bus
        bus_write(16'hA000, 8'h01);
        repeat (5000) @(negedge sys_clock);
        @(negedge sys_clock);
        cart_a = 16'hA000; cart_nCS = 1'b0; cart_nRD = 1'b0; tb_d = 8'h5A; tb_den = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge sys_clock);
        chk("abort sens", 16'({sens_xck, sens_reset, sens_load, sens_sin, sens_start, sens_read}), 16'h0);
        chk("abort cart_d released", 16'(cart_d), 16'h5A);
        chk("abort nCS/nWE", 16'({rom_nCS, ram_nCS, ram_nWE}), 16'h7);
        chk("abort nRST/ce2", 16'({cart_nRST, ram_ce2}), 16'h0);
        chk("abort banks", {debug_ROM_BANK, debug_RAM_BANK}, 16'h0);
        chk("abort bram", 16'(debug_bram_output), 16'h0);
        reset = 1'b0; tb_den = 1'b0; cart_nRD = 1'b1; cart_nCS = 1'b1;
        repeat (10) @(negedge sys_clock);
        read_chk("post-abort rom", 16'h6000, 8'h00);
        bus_write(16'h4000, 8'h10);
        read_chk("post-abort busy", 16'hA000, 8'hE0);
        repeat (3000) @(negedge sys_clock);
        chk("post-abort start pulses", 16'(start_cnt), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
